// File: rtl/elm_pkg.sv
// Shared constants and FSM encoding for the ELM accuracy tracker slice.
package elm_pkg;

  localparam int ELM_NUM_CLASSES = 10;
  localparam int ELM_LABEL_W     = 4;
  localparam int ELM_CNT_W       = 16;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_PRED = 2'd1,
    S_UPDATE    = 2'd2
  } elm_state_t;

endpackage

// File: rtl/elm_accuracy_tracker_if.sv
// Label/prediction handshake bundle between the label source, max finder and tracker.
// A label transfers on a rising edge where label_valid && label_ready; label_valid
// and label must stay stable until then. pred_valid is a one-cycle pulse with no
// backpressure: the tracker samples it on every edge and never stalls the source.
interface elm_accuracy_tracker_if #(
  parameter int LABEL_W = elm_pkg::ELM_LABEL_W
) ();
  logic               label_valid;
  logic [LABEL_W-1:0] label;
  logic               label_ready;
  logic               pred_valid;
  logic [LABEL_W-1:0] pred;

  modport master (
    output label_valid, label, pred_valid, pred,
    input  label_ready
  );

  modport slave (
    input  label_valid, label, pred_valid, pred,
    output label_ready
  );
endinterface

// File: rtl/elm_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module elm_sat_counter #(
  parameter int W = elm_pkg::ELM_CNT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/elm_accuracy_tracker.sv
// Scores one classifier result per true label; keeps saturating global and
// per-class hit/total counters, a timeout-miss count and sticky error flags.
module elm_accuracy_tracker
  import elm_pkg::*;
#(
  parameter int NUM_CLASSES = ELM_NUM_CLASSES,
  parameter int LABEL_W     = ELM_LABEL_W,
  parameter int CNT_W       = ELM_CNT_W,
  parameter int TIMEOUT     = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  elm_accuracy_tracker_if.slave bus,
  output logic [CNT_W-1:0]     total_cnt,
  output logic [CNT_W-1:0]     correct_cnt,
  output logic [CNT_W-1:0]     miss_cnt,
  input  logic [LABEL_W-1:0]   rd_class,
  output logic [CNT_W-1:0]     rd_correct,
  output logic [CNT_W-1:0]     rd_total,
  output logic                 err_orphan,
  output logic                 err_range,
  output elm_state_t           dbg_state
);

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [LABEL_W:0]   NUM_CLASSES_X = (LABEL_W + 1)'(NUM_CLASSES);

  elm_state_t          state, next_state;
  logic [LABEL_W-1:0]  lbl_q;
  logic                hit_q;
  logic                miss_q;
  logic [WAIT_W-1:0]   wait_cnt;

  logic capture, latch_pred, latch_miss, do_update, orphan_set;
  logic timeout_hit;
  logic lbl_in_range;

  logic [CNT_W-1:0] cls_correct [NUM_CLASSES];
  logic [CNT_W-1:0] cls_total   [NUM_CLASSES];
  logic [CNT_W-1:0] sel_correct, sel_total;

  assign dbg_state       = state;
  assign bus.label_ready = (state == S_IDLE);
  assign lbl_in_range    = ({1'b0, lbl_q} < NUM_CLASSES_X);
  assign timeout_hit     = (TIMEOUT > 0) && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    latch_pred = 1'b0;
    latch_miss = 1'b0;
    do_update  = 1'b0;
    orphan_set = 1'b0;
    case (state)
      S_IDLE: begin
        // A pred here has no label to score against; the label (if any) is still taken.
        orphan_set = bus.pred_valid;
        if (bus.label_valid) begin
          capture    = 1'b1;
          next_state = S_WAIT_PRED;
        end
      end
      S_WAIT_PRED: begin
        if (bus.pred_valid) begin
          latch_pred = 1'b1;
          next_state = S_UPDATE;
        end else if (timeout_hit) begin
          latch_miss = 1'b1;
          next_state = S_UPDATE;
        end
      end
      S_UPDATE: begin
        do_update  = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    if (clear) begin
      next_state = S_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lbl_q      <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      wait_cnt   <= '0;
      err_orphan <= 1'b0;
      err_range  <= 1'b0;
      rd_correct <= '0;
      rd_total   <= '0;
    end else if (clear) begin
      lbl_q      <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      wait_cnt   <= '0;
      err_orphan <= 1'b0;
      err_range  <= 1'b0;
      rd_correct <= '0;
      rd_total   <= '0;
    end else begin
      if (capture) begin
        lbl_q    <= bus.label;
        hit_q    <= 1'b0;
        miss_q   <= 1'b0;
        wait_cnt <= '0;
      end else if (state == S_WAIT_PRED) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (latch_pred) begin
        hit_q <= (bus.pred == lbl_q);
      end
      if (latch_miss) begin
        miss_q <= 1'b1;
      end
      if (orphan_set) begin
        err_orphan <= 1'b1;
      end
      if (do_update && !lbl_in_range) begin
        err_range <= 1'b1;
      end
      // Readout reflects counters before this edge; no bypass of a same-cycle update.
      rd_correct <= sel_correct;
      rd_total   <= sel_total;
    end
  end

  always_comb begin
    sel_correct = '0;
    sel_total   = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (rd_class == LABEL_W'(c)) begin
        sel_correct = cls_correct[c];
        sel_total   = cls_total[c];
      end
    end
  end

  elm_sat_counter #(.W(CNT_W)) u_total_cnt (
    .clock (clock), .reset (reset), .clear (clear),
    .inc   (do_update), .count (total_cnt)
  );

  elm_sat_counter #(.W(CNT_W)) u_correct_cnt (
    .clock (clock), .reset (reset), .clear (clear),
    .inc   (do_update && hit_q), .count (correct_cnt)
  );

  elm_sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clock (clock), .reset (reset), .clear (clear),
    .inc   (do_update && miss_q), .count (miss_cnt)
  );

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_class
    logic cls_sel;
    assign cls_sel = do_update && lbl_in_range && (lbl_q == LABEL_W'(c));

    elm_sat_counter #(.W(CNT_W)) u_cls_total (
      .clock (clock), .reset (reset), .clear (clear),
      .inc   (cls_sel), .count (cls_total[c])
    );

    elm_sat_counter #(.W(CNT_W)) u_cls_correct (
      .clock (clock), .reset (reset), .clear (clear),
      .inc   (cls_sel && hit_q), .count (cls_correct[c])
    );
  end

endmodule

// File: tb/tb_elm_accuracy_tracker.sv
// Directed bench for elm_accuracy_tracker: expected global counts are queued per
// scored image and compared by a monitor when the DUT leaves UPDATE.
module tb_elm_accuracy_tracker;
  import elm_pkg::*;

  localparam int NC  = 10;
  localparam int LW  = 4;
  localparam int CW  = 3;
  localparam int TO  = 4;
  localparam int EW  = 3 * CW;

  logic          clock;
  logic          reset;
  logic          clear;
  logic [LW-1:0] rd_class;
  logic [CW-1:0] total_cnt, correct_cnt, miss_cnt;
  logic [CW-1:0] rd_correct, rd_total;
  logic          err_orphan, err_range;
  elm_state_t    dbg_state;

  elm_accuracy_tracker_if #(.LABEL_W(LW)) bus ();

  elm_accuracy_tracker #(
    .NUM_CLASSES (NC),
    .LABEL_W     (LW),
    .CNT_W       (CW),
    .TIMEOUT     (TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .bus         (bus.slave),
    .total_cnt   (total_cnt),
    .correct_cnt (correct_cnt),
    .miss_cnt    (miss_cnt),
    .rd_class    (rd_class),
    .rd_correct  (rd_correct),
    .rd_total    (rd_total),
    .err_orphan  (err_orphan),
    .err_range   (err_range),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic was_update = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push_exp(input logic [CW-1:0] t, input logic [CW-1:0] c, input logic [CW-1:0] m);
    exp_q.push_back({t, c, m});
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      was_update = 1'b0;
    end else begin
      if (was_update) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL score_unexpected: got total %0d expected no score", total_cnt);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("score_total",   32'(total_cnt),   32'(e[3*CW-1:2*CW]));
          check("score_correct", 32'(correct_cnt), 32'(e[2*CW-1:CW]));
          check("score_miss",    32'(miss_cnt),    32'(e[CW-1:0]));
        end
      end
      was_update = (dbg_state == S_UPDATE);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (bus.label_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      chk_cnt++;
      $display("FAIL idle_wait: got label_ready %0b expected 1 within 40 cycles", bus.label_ready);
    end
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic send_image(input logic [LW-1:0] l, input logic [LW-1:0] p);
    wait_idle();
    bus.label_valid = 1'b1;
    bus.label       = l;
    tick();
    bus.label_valid = 1'b0;
    bus.pred_valid  = 1'b1;
    bus.pred        = p;
    tick();
    bus.pred_valid  = 1'b0;
    tick();
  endtask

  task automatic read_check(input int c, input int ec, input int et);
    rd_class = LW'(c);
    tick();
    check($sformatf("rd_correct[%0d]", c), 32'(rd_correct), 32'(ec));
    check($sformatf("rd_total[%0d]", c),   32'(rd_total),   32'(et));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset           = 1'b0;
    clear           = 1'b0;
    rd_class        = '0;
    bus.label_valid = 1'b0;
    bus.label       = '0;
    bus.pred_valid  = 1'b0;
    bus.pred        = '0;
    tick();
    tick();
    check("rst_total",       32'(total_cnt),   0);
    check("rst_correct",     32'(correct_cnt), 0);
    check("rst_miss",        32'(miss_cnt),    0);
    check("rst_rd_total",    32'(rd_total),    0);
    check("rst_label_ready", 32'(bus.label_ready), 1);
    check("rst_err_orphan",  32'(err_orphan),  0);
    check("rst_state",       32'(dbg_state),   32'(S_IDLE));
    reset = 1'b1;
    tick();

    // Basic scoring: labels 3,7,7 against preds 3,2,7.
    do_clear();
    push_exp(3'd1, 3'd1, 3'd0); send_image(4'd3, 4'd3);
    push_exp(3'd2, 3'd1, 3'd0); send_image(4'd7, 4'd2);
    push_exp(3'd3, 3'd2, 3'd0); send_image(4'd7, 4'd7);
    read_check(7, 1, 2);
    read_check(3, 1, 1);
    check("basic_err_orphan", 32'(err_orphan), 0);

    // One score per label: pred held for three edges; the third lands in IDLE.
    do_clear();
    push_exp(3'd1, 3'd1, 3'd0);
    wait_idle();
    bus.label_valid = 1'b1; bus.label = 4'd5;
    tick();
    bus.label_valid = 1'b0;
    bus.pred_valid = 1'b1; bus.pred = 4'd5;
    tick(); tick(); tick();
    bus.pred_valid = 1'b0;
    check("dup_err_orphan", 32'(err_orphan), 1);
    tick();
    check("dup_total",   32'(total_cnt),   1);
    check("dup_correct", 32'(correct_cnt), 1);
    read_check(5, 1, 1);

    // Orphan pred with nothing pending.
    do_clear();
    check("clr_err_orphan", 32'(err_orphan), 0);
    bus.pred_valid = 1'b1; bus.pred = 4'd3;
    tick();
    bus.pred_valid = 1'b0;
    check("orphan_flag",  32'(err_orphan), 1);
    check("orphan_total", 32'(total_cnt),  0);
    check("orphan_state", 32'(dbg_state),  32'(S_IDLE));

    // Timeout: label 2 at edge k, miss scored after edge k+5.
    do_clear();
    push_exp(3'd1, 3'd0, 3'd1);
    wait_idle();
    bus.label_valid = 1'b1; bus.label = 4'd2;
    tick();
    bus.label_valid = 1'b0;
    tick(); tick(); tick();
    check("to_still_waiting", 32'(dbg_state), 32'(S_WAIT_PRED));
    check("to_total_k3",      32'(total_cnt), 0);
    tick();
    check("to_update_k4",     32'(dbg_state), 32'(S_UPDATE));
    tick();
    check("to_miss_k5",       32'(miss_cnt),  1);
    check("to_ready_k5",      32'(bus.label_ready), 1);
    read_check(2, 0, 1);
    bus.pred_valid = 1'b1; bus.pred = 4'd2;
    tick();
    bus.pred_valid = 1'b0;
    check("to_late_orphan", 32'(err_orphan), 1);
    check("to_late_total",  32'(total_cnt),  1);

    // Out-of-range label 12.
    do_clear();
    push_exp(3'd1, 3'd1, 3'd0);
    send_image(4'd12, 4'd12);
    check("oor_err_range", 32'(err_range), 1);
    for (int c = 0; c < NC; c++) read_check(c, 0, 0);
    read_check(12, 0, 0);
    read_check(15, 0, 0);

    // Saturation at 7 with nine correct class-1 images.
    do_clear();
    for (int i = 1; i <= 9; i++) begin
      logic [CW-1:0] e;
      e = (i > 7) ? 3'd7 : CW'(i);
      push_exp(e, e, 3'd0);
      send_image(4'd1, 4'd1);
    end
    read_check(1, 7, 7);
    read_check(0, 0, 0);

    // Clear with counters and readout nonzero.
    rd_class = 4'd1;
    tick();
    check("pre_clear_rd_total", 32'(rd_total), 7);
    do_clear();
    check("clr_total",      32'(total_cnt),   0);
    check("clr_correct",    32'(correct_cnt), 0);
    check("clr_rd_total",   32'(rd_total),    0);
    check("clr_rd_correct", 32'(rd_correct),  0);

    // Asynchronous reset in WAIT_PRED.
    push_exp(3'd1, 3'd1, 3'd0);
    send_image(4'd6, 4'd6);
    wait_idle();
    bus.label_valid = 1'b1; bus.label = 4'd4;
    tick();
    bus.label_valid = 1'b0;
    check("rst_mid_wait_state", 32'(dbg_state), 32'(S_WAIT_PRED));
    #2;
    reset = 1'b0;
    #1;
    check("arst_total",       32'(total_cnt),   0);
    check("arst_correct",     32'(correct_cnt), 0);
    check("arst_label_ready", 32'(bus.label_ready), 1);
    check("arst_state",       32'(dbg_state),   32'(S_IDLE));
    #2;
    reset = 1'b1;
    push_exp(3'd1, 3'd1, 3'd0);
    send_image(4'd4, 4'd4);
    read_check(4, 1, 1);

    tick();
    tick();
    chk_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL sb_drain: got %0d pending scores expected 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/elm_accuracy_tracker.md
# elm_accuracy_tracker

Parametrised accuracy scoreboard for the ELM inference engine. It captures the true label of each image, waits for the classifier's result pulse, and scores exactly one result per label. It keeps saturating global and per-class correct/total counters plus a timeout-miss count, and provides a registered per-class readout port. It sits beside the top-level datapath, fed by the label source and by the max-finder's index/update outputs.

## Interface
- `NUM_CLASSES`, 10: number of output classes; labels 0..NUM_CLASSES-1 are valid.
- `LABEL_W`, 4: label/prediction width; must satisfy 2^LABEL_W >= NUM_CLASSES.
- `CNT_W`, 16: width of every counter.
- `TIMEOUT`, 0: cycles to wait for a prediction after a label is accepted; 0 = wait forever.

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `clear`  in  1  synchronous clear of all counters, flags and the FSM.
- `label_valid`  in  1  true label presented.
- `label`  in  LABEL_W  true class of the current image.
- `label_ready`  out  1  high when a label can be accepted (state IDLE).
- `pred_valid`  in  1  one-cycle result pulse from the max finder.
- `pred`  in  LABEL_W  recognised class.
- `total_cnt`, `correct_cnt`, `miss_cnt`  out  CNT_W  global counters.
- `rd_class`  in  LABEL_W  class selected for readout.
- `rd_correct`, `rd_total`  out  CNT_W  per-class counters for `rd_class`, registered.
- `err_orphan`  out  1  sticky flag: a prediction arrived with no label pending.
- `err_range`  out  1  sticky flag: a label >= NUM_CLASSES was accepted.

## Operation
- FSM states: IDLE, WAIT_PRED, UPDATE.
- IDLE: `label_ready`=1. If `label_valid`=1, capture `label` and go to WAIT_PRED; clear the timeout counter.
- IDLE with `pred_valid`=1: set `err_orphan` and update no counters. This also applies when `label_valid` is high in the same cycle; that label is still captured.
- WAIT_PRED: the first `pred_valid` latches `pred` and the hit flag (`pred`==captured label), then goes to UPDATE. While waiting, `label_valid` is ignored.
- WAIT_PRED timeout: if `TIMEOUT`>0 and the wait counter reaches `TIMEOUT` with no `pred_valid`, latch miss=1 and go to UPDATE.
- UPDATE (one cycle), then return to IDLE:
  - `total_cnt` increments.
  - `correct_cnt` increments on a hit.
  - `miss_cnt` increments on a timeout.
  - If the label is in range: per-class total increments, and per-class correct increments on a hit.
  - If the label is out of range: `err_range` is set and per-class counters are untouched. Global counters still update.
- Extra `pred_valid` pulses in UPDATE are ignored silently: one score per label.
- All counters saturate at 2^CNT_W-1 and never wrap. Saturation of one counter does not block the others.
- An out-of-range `rd_class` returns 0 on both readout ports.
- `clear` has priority over all FSM activity. It zeroes every counter and flag and forces IDLE.

## Timing
- Reset values: all counters 0, `rd_*` = 0, flags 0, state IDLE, `label_ready`=1.
- Asynchronous reset assertion takes effect immediately, including mid-wait; the pending label is discarded.
- Label accepted at edge k; `label_ready`=0 from k.
- `pred_valid` sampled at edge m: UPDATE during cycle m..m+1, counters visible after edge m+1, `label_ready`=1 after edge m+1.
- Minimum image interval: 3 cycles.
- Timeout: with label accepted at edge k, the miss is scored after edge k+TIMEOUT+1.
- `rd_correct`/`rd_total`: 1-cycle latency from `rd_class`. They reflect counter values as of the previous edge, with no same-cycle bypass.

## Structure
- Shared package `elm_pkg`: NUM_CLASSES/LABEL_W defaults, the FSM state enum, and a counter-width constant.
- Sub-module `elm_sat_counter`: parameter W; ports clear, inc, count. It is instantiated 3 + 2·NUM_CLASSES times.
- The per-class counters are flat register arrays; no RAM.

## Test plan
- **Basic scoring.** Send labels 3, 7, 7 with preds 3, 2, 7. Expect total=3, correct=2, rd_class=7 gives total 2 / correct 1, rd_class=3 gives 1/1.
- **Duplicate and orphan predictions.** Label 5, then pred 5 pulsed three times in a row: expect total=1, correct=1. A pred with no label pending: `err_orphan`=1, counters unchanged.
- **Timeout.** TIMEOUT=4, label 2, no pred: `miss_cnt`=1, total=1, correct=0, class 2 total=1. A late pred then sets `err_orphan`.
- **Out-of-range label.** Label 12 with NUM_CLASSES=10, pred 12: total=1, correct=1, `err_range`=1, every class readout 0, and rd_class=12 reads 0.
- **Saturation.** CNT_W=3, nine correct images of class 1: total=correct=7, and class 1 reads 7/7.
- **Reset and clear mid-operation.** Assert `reset` low in WAIT_PRED: outputs return to 0 immediately and the next label is accepted normally. Pulse `clear` with counters nonzero: all counters 0 on the following cycle.
